// File: rtl/ip_codma_mem_arbiter.sv
// Two-master to one-slave memory arbiter with address/data phase tracking and a data-phase watchdog.
// Optional round-robin arbitration of simultaneous requests: define CODMA_ARB_ROUND_ROBIN_EN.
module ip_codma_mem_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        m0_read,
  input  logic        m0_write,
  input  logic [31:0] m0_addr,
  input  logic [3:0]  m0_size,
  input  logic [63:0] m0_write_data,
  input  logic        m0_write_valid,
  output logic        m0_grant,
  output logic [63:0] m0_read_data,
  output logic        m0_read_valid,
  output logic        m0_error,
  input  logic        m1_read,
  input  logic        m1_write,
  input  logic [31:0] m1_addr,
  input  logic [3:0]  m1_size,
  input  logic [63:0] m1_write_data,
  input  logic        m1_write_valid,
  output logic        m1_grant,
  output logic [63:0] m1_read_data,
  output logic        m1_read_valid,
  output logic        m1_error,
  output logic        s_read,
  output logic        s_write,
  output logic [31:0] s_addr,
  output logic [3:0]  s_size,
  output logic [63:0] s_write_data,
  output logic        s_write_valid,
  input  logic        s_grant,
  input  logic [63:0] s_read_data,
  input  logic        s_read_valid,
  input  logic        s_error,
  output logic [1:0]  arb_owner
);

  localparam int unsigned WdW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {StIdle, StAddr, StData} state_e;

  state_e           state_q;
  logic             owner_q;
  logic             dir_write_q;
  logic [2:0]       beats_q;
  logic [WdW-1:0]   wd_q;
`ifdef CODMA_ARB_ROUND_ROBIN_EN
  logic             last_owner_q;
`endif

  logic        own_read, own_write, own_req, own_wvalid;
  logic [31:0] own_addr;
  logic [3:0]  own_size;
  logic [63:0] own_wdata;
  logic        pick;
  logic        beat_evt, last_beat, timeout;
  logic        grant_o, rvalid_o, error_o;

  assign own_read   = owner_q ? m1_read        : m0_read;
  assign own_write  = owner_q ? m1_write       : m0_write;
  assign own_addr   = owner_q ? m1_addr        : m0_addr;
  assign own_size   = owner_q ? m1_size        : m0_size;
  assign own_wdata  = owner_q ? m1_write_data  : m0_write_data;
  assign own_wvalid = owner_q ? m1_write_valid : m0_write_valid;
  assign own_req    = own_read | own_write;

`ifdef CODMA_ARB_ROUND_ROBIN_EN
  assign pick = (m0_read | m0_write) & (m1_read | m1_write) ? ~last_owner_q
                                                            : ~(m0_read | m0_write);
`else
  assign pick = ~(m0_read | m0_write);
`endif

  assign beat_evt  = dir_write_q ? own_wvalid : s_read_valid;
  assign last_beat = beat_evt && (beats_q == 3'd1);
  assign timeout   = (wd_q == WdW'(TIMEOUT_CYCLES));

  assign m0_read_data = s_read_data;
  assign m1_read_data = s_read_data;

  function automatic logic [2:0] size_to_beats(input logic [3:0] size);
    case (size)
      4'd1:    return 3'd2;
      4'd2:    return 3'd4;
      default: return 3'd1;
    endcase
  endfunction

  always_comb begin
    s_read        = 1'b0;
    s_write       = 1'b0;
    s_addr        = '0;
    s_size        = '0;
    s_write_data  = '0;
    s_write_valid = 1'b0;
    grant_o       = 1'b0;
    rvalid_o      = 1'b0;
    error_o       = 1'b0;
    arb_owner     = '0;
    if (!reset) begin
      arb_owner = {state_q != StIdle, owner_q};
      case (state_q)
        StAddr: begin
          // Read wins when a master raises both directions.
          s_read  = own_read;
          s_write = own_write & ~own_read;
          s_addr  = own_addr;
          s_size  = own_size;
          grant_o = s_grant & own_req;
        end
        StData: begin
          s_write_data  = own_wdata;
          s_write_valid = dir_write_q & own_wvalid;
          rvalid_o      = ~dir_write_q & s_read_valid;
          error_o       = s_error | timeout;
        end
        default: ;
      endcase
    end
  end

  assign m0_grant      = grant_o  & ~owner_q;
  assign m1_grant      = grant_o  &  owner_q;
  assign m0_read_valid = rvalid_o & ~owner_q;
  assign m1_read_valid = rvalid_o &  owner_q;
  assign m0_error      = error_o  & ~owner_q;
  assign m1_error      = error_o  &  owner_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= StIdle;
      owner_q      <= 1'b0;
      dir_write_q  <= 1'b0;
      beats_q      <= '0;
      wd_q         <= '0;
`ifdef CODMA_ARB_ROUND_ROBIN_EN
      last_owner_q <= 1'b1;
`endif
    end else begin
      case (state_q)
        StIdle: begin
          if (m0_read | m0_write | m1_read | m1_write) begin
            owner_q <= pick;
            state_q <= StAddr;
          end
        end
        StAddr: begin
          if (!own_req) begin
            owner_q <= 1'b0;
            state_q <= StIdle;
          end else if (s_grant) begin
            dir_write_q  <= ~own_read;
            beats_q      <= size_to_beats(own_size);
            wd_q         <= '0;
`ifdef CODMA_ARB_ROUND_ROBIN_EN
            last_owner_q <= owner_q;
`endif
            state_q      <= StData;
          end
        end
        StData: begin
          wd_q <= wd_q + WdW'(1);
          if (s_error || timeout || last_beat) begin
            owner_q <= 1'b0;
            state_q <= StIdle;
          end else if (beat_evt) begin
            beats_q <= beats_q - 3'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_ip_codma_mem_arbiter.sv
// Directed self-checking bench for ip_codma_mem_arbiter (watchdog configured to 8 cycles).
module tb_ip_codma_mem_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        m0_read, m0_write, m0_write_valid, m0_grant, m0_read_valid, m0_error;
  logic [31:0] m0_addr;
  logic [3:0]  m0_size;
  logic [63:0] m0_write_data, m0_read_data;
  logic        m1_read, m1_write, m1_write_valid, m1_grant, m1_read_valid, m1_error;
  logic [31:0] m1_addr;
  logic [3:0]  m1_size;
  logic [63:0] m1_write_data, m1_read_data;
  logic        s_read, s_write, s_write_valid, s_grant, s_read_valid, s_error;
  logic [31:0] s_addr;
  logic [3:0]  s_size;
  logic [63:0] s_write_data, s_read_data;
  logic [1:0]  arb_owner;

  int total = 0;
  int bad   = 0;
  logic exp2;

  always #5 clock = ~clock;

  ip_codma_mem_arbiter #(.TIMEOUT_CYCLES(8)) dut (
    .clock(clock), .reset(reset),
    .m0_read(m0_read), .m0_write(m0_write), .m0_addr(m0_addr), .m0_size(m0_size),
    .m0_write_data(m0_write_data), .m0_write_valid(m0_write_valid), .m0_grant(m0_grant),
    .m0_read_data(m0_read_data), .m0_read_valid(m0_read_valid), .m0_error(m0_error),
    .m1_read(m1_read), .m1_write(m1_write), .m1_addr(m1_addr), .m1_size(m1_size),
    .m1_write_data(m1_write_data), .m1_write_valid(m1_write_valid), .m1_grant(m1_grant),
    .m1_read_data(m1_read_data), .m1_read_valid(m1_read_valid), .m1_error(m1_error),
    .s_read(s_read), .s_write(s_write), .s_addr(s_addr), .s_size(s_size),
    .s_write_data(s_write_data), .s_write_valid(s_write_valid), .s_grant(s_grant),
    .s_read_data(s_read_data), .s_read_valid(s_read_valid), .s_error(s_error),
    .arb_owner(arb_owner)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Entered in the first ADDR cycle of a read by `own`; grants, streams beats, ends in IDLE.
  task automatic serve(input logic own, input int beats);
    s_grant = 1'b1;
    #1;
    chk("grant_own", own ? m1_grant : m0_grant, 1);
    chk("grant_other", own ? m0_grant : m1_grant, 0);
    tick();
    s_grant = 1'b0;
    if (own) m1_read = 1'b0; else m0_read = 1'b0;
    for (int i = 0; i < beats; i++) begin
      s_read_valid = 1'b1;
      s_read_data  = {32'hCAFE0000, 32'(i)};
      #1;
      chk("rv_own", own ? m1_read_valid : m0_read_valid, 1);
      chk("rv_other", own ? m0_read_valid : m1_read_valid, 0);
      chk("rdata", own ? m1_read_data : m0_read_data, {32'hCAFE0000, 32'(i)});
      tick();
    end
    s_read_valid = 1'b0;
    #1;
    chk("idle_after_burst", arb_owner, 0);
  endtask

  initial begin
    reset = 1'b1;
    {m0_read, m0_write, m0_write_valid, m1_read, m1_write, m1_write_valid} = '0;
    m0_addr = '0; m0_size = '0; m0_write_data = '0;
    m1_addr = '0; m1_size = '0; m1_write_data = '0;
    s_grant = 1'b0; s_read_valid = 1'b0; s_error = 1'b0; s_read_data = '0;
    tick();
    tick();
    chk("rst_owner", arb_owner, 0);
    chk("rst_s_read", s_read, 0);
    chk("rst_grant", {m0_grant, m1_grant}, 0);
    reset = 1'b0;
    tick();
    chk("idle_owner", arb_owner, 0);

    // Simultaneous 4-beat reads, then m0 re-requests while m1 is still waiting.
    m0_read = 1'b1; m0_size = 4'd2; m0_addr = 32'h1000;
    m1_read = 1'b1; m1_size = 4'd2; m1_addr = 32'h2000;
    tick();
    chk("sim_owner1", arb_owner, 2'b10);
    chk("sim_addr1", s_addr, 32'h1000);
    serve(1'b0, 4);
    m0_read = 1'b1;
`ifdef CODMA_ARB_ROUND_ROBIN_EN
    exp2 = 1'b1;
`else
    exp2 = 1'b0;
`endif
    tick();
    chk("sim_owner2", arb_owner, {1'b1, exp2});
    serve(exp2, 4);
    tick();
    chk("sim_owner3", arb_owner, {1'b1, ~exp2});
    serve(~exp2, 4);

    // Single read with a slave grant two cycles after the request.
    m0_read = 1'b1; m0_addr = 32'h100; m0_size = 4'd0;
    #1;
    chk("s1_idle_s_read", s_read, 0);
    tick();
    chk("s1_s_read", s_read, 1);
    chk("s1_s_addr", s_addr, 32'h100);
    chk("s1_nogrant", m0_grant, 0);
    tick();
    s_grant = 1'b1;
    #1;
    chk("s1_grant", {m0_grant, m1_grant}, 2'b10);
    tick();
    s_grant = 1'b0; m0_read = 1'b0;
    s_read_valid = 1'b1; s_read_data = 64'hDEADBEEF_00000001;
    #1;
    chk("s1_data_s_read", s_read, 0);
    chk("s1_rv", {m0_read_valid, m1_read_valid}, 2'b10);
    chk("s1_rdata", m0_read_data, 64'hDEADBEEF_00000001);
    chk("s1_m1_rdata", m1_read_data, 64'hDEADBEEF_00000001);
    tick();
    s_read_valid = 1'b0;
    #1;
    chk("s1_idle", arb_owner, 0);
    chk("s1_rv_off", m0_read_valid, 0);

    // Two-beat write burst from m1; m0 write inputs must not leak through.
    m1_write = 1'b1; m1_size = 4'd1; m1_addr = 32'h200;
    tick();
    chk("wr_owner", arb_owner, 2'b11);
    chk("wr_dir", {s_read, s_write}, 2'b01);
    s_grant = 1'b1;
    #1;
    chk("wr_grant", {m0_grant, m1_grant}, 2'b01);
    tick();
    s_grant = 1'b0; m1_write = 1'b0;
    m0_write_valid = 1'b1; m0_write_data = 64'hFF;
    m1_write_valid = 1'b1; m1_write_data = 64'h11;
    #1;
    chk("wr_beat0", {s_write_valid, s_write_data}, {1'b1, 64'h11});
    chk("wr_data_s_write", s_write, 0);
    tick();
    m1_write_data = 64'h22;
    #1;
    chk("wr_beat1", {s_write_valid, s_write_data}, {1'b1, 64'h22});
    tick();
    m0_write_valid = 1'b0; m1_write_valid = 1'b0;
    #1;
    chk("wr_idle", arb_owner, 0);
    chk("wr_wv_off", s_write_valid, 0);

    // Slave error on the 2nd of 4 read beats; m0 raises read and write together.
    m0_read = 1'b1; m0_write = 1'b1; m0_size = 4'd2;
    tick();
    chk("err_dir", {s_read, s_write}, 2'b10);
    s_grant = 1'b1;
    tick();
    s_grant = 1'b0; m0_read = 1'b0; m0_write = 1'b0;
    s_read_valid = 1'b1;
    #1;
    chk("err_beat0", m0_read_valid, 1);
    tick();
    s_read_valid = 1'b0; s_error = 1'b1;
    #1;
    chk("err_pulse", {m0_error, m1_error}, 2'b10);
    tick();
    s_error = 1'b0;
    #1;
    chk("err_idle", arb_owner, 0);
    chk("err_pulse_off", m0_error, 0);

    // Watchdog: granted m1 read with no response.
    m1_read = 1'b1; m1_size = 4'd0;
    tick();
    s_grant = 1'b1;
    tick();
    s_grant = 1'b0; m1_read = 1'b0;
    #1;
    chk("wd_entry_err", m1_error, 0);
    for (int i = 1; i < 8; i++) begin
      tick();
      chk("wd_early_err", m1_error, 0);
    end
    tick();
    chk("wd_pulse", {m0_error, m1_error}, 2'b01);
    chk("wd_owner", arb_owner, 2'b11);
    tick();
    chk("wd_idle", arb_owner, 0);
    chk("wd_pulse_off", m1_error, 0);
    s_read_valid = 1'b1;
    #1;
    chk("wd_late_rv", {m0_read_valid, m1_read_valid}, 0);
    s_read_valid = 1'b0;

    // Reset asserted during beat 1 of a 4-beat read.
    m0_read = 1'b1; m0_size = 4'd2;
    tick();
    s_grant = 1'b1;
    tick();
    s_grant = 1'b0; m0_read = 1'b0;
    s_read_valid = 1'b1; reset = 1'b1;
    tick();
    reset = 1'b0; s_read_valid = 1'b0;
    #1;
    chk("rstd_owner", arb_owner, 0);
    chk("rstd_outs", {s_read, s_write, s_write_valid, m0_read_valid, m0_error, m1_error}, 0);
    m1_read = 1'b1; m1_size = 4'd0;
    tick();
    chk("rstd_new_owner", arb_owner, 2'b11);
    serve(1'b1, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
